// File: rtl/jogo_playseq.sv
// Simon-style memory game: shows growing prefixes of a 16-entry one-hot sequence
// and checks the player's repetition of each round's new entries.
module jogo_playseq #(
    parameter int CYCLES_PER_SEC = 50_000
) (
    input  logic       clockFPGA,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    input  logic [1:0] nivel,
    input  logic [1:0] memoria,
    input  logic       quer_escrever,
    input  logic [1:0] timeoutD,
    input  logic       ignora_timeout,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       buzzer,
    output logic       db_clock,
    output logic       db_tem_jogada,
    output logic       db_chavesIgualMemoria,
    output logic       db_enderecoIgualSequencia,
    output logic       db_fimS,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_sequencia,
    output logic [6:0] db_estado,
    output logic       db_seletor_memoria,
    output logic       db_pare,
    output logic [1:0] db_contagem_jogo,
    output logic [6:0] vitorias,
    output logic [6:0] derrotas
);
    localparam int TW = $clog2(5 * CYCLES_PER_SEC + 1);
    localparam logic [TW-1:0] HALF_T  = TW'(CYCLES_PER_SEC / 2);
    localparam logic [TW-1:0] HALF_M1 = TW'(CYCLES_PER_SEC / 2 - 1);
    localparam logic [TW-1:0] SEC_M1  = TW'(CYCLES_PER_SEC - 1);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        ESCREVE    = 4'h1,
        PREPARA    = 4'h3,
        MOSTRA     = 4'h4,
        ESPERA     = 4'h5,
        JOGADA     = 4'h6,
        COMPARA    = 4'h7,
        FIM_RODADA = 4'h8,
        GANHOU     = 4'hC,
        PERDEU     = 4'hD
    } estado_t;

    function automatic logic [3:0] rom(input logic [1:0] sel, input logic [1:0] idx);
        logic [3:0] v;
        case (sel)
            2'd0:    v = 4'b0001 << idx;
            2'd1:    v = 4'b1000 >> idx;
            default: case (idx)
                2'd0:    v = 4'b0001;
                2'd1:    v = 4'b0100;
                2'd2:    v = 4'b0010;
                default: v = 4'b1000;
            endcase
        endcase
        return v;
    endfunction

    // Segment patterns are listed active-high (gfedcba) and inverted on return.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return ~p;
    endfunction

    estado_t       estado;
    logic          jogar_q, tem_q;
    logic [3:0]    addr, fim, inicio, jogada, vit, der, mem_data, leds_next;
    logic [1:0]    niv, cont;
    logic [TW-1:0] timer, limite_m1, clk_cnt;
    logic [3:0]    ram [16];
    logic [4:0]    soma;
    logic          jogar_ev, press, igual, dispara;

    assign jogar_ev  = jogar & ~jogar_q;
    assign press     = (|botoes) & ~tem_q;
    assign mem_data  = (memoria == 2'd3) ? ram[addr] : rom(memoria, addr[1:0]);
    assign igual     = (jogada == mem_data);
    assign soma      = {1'b0, fim} + {3'b000, niv} + 5'd1;
    assign limite_m1 = TW'((int'(timeoutD) + 2) * CYCLES_PER_SEC - 1);
    // jogar only restarts the game from idle, a finished write or a finished game.
    assign dispara   = jogar_ev && (estado == INICIAL || estado == GANHOU || estado == PERDEU ||
                                    (estado == ESCREVE && pronto));

    always_comb begin
        leds_next = '0;
        case (estado)
            MOSTRA:  if (timer < HALF_T) leds_next = mem_data;
            JOGADA:  leds_next = botoes;
            ESCREVE: if (!pronto) leds_next = botoes;
            default: ;
        endcase
    end

    always_ff @(posedge clockFPGA or negedge reset) begin
        if (!reset) begin
            clk_cnt  <= '0;
            db_clock <= 1'b0;
        end else if (clk_cnt == HALF_M1) begin
            clk_cnt  <= '0;
            db_clock <= ~db_clock;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clockFPGA or negedge reset) begin
        if (!reset) begin
            estado  <= INICIAL;
            jogar_q <= 1'b0;
            tem_q   <= 1'b0;
            jogada  <= '0;
            addr    <= '0;
            fim     <= '0;
            inicio  <= '0;
            niv     <= '0;
            cont    <= '0;
            timer   <= '0;
            vit     <= '0;
            der     <= '0;
            leds    <= '0;
            ganhou  <= 1'b0;
            perdeu  <= 1'b0;
            timeout <= 1'b0;
            pronto  <= 1'b0;
            for (int i = 0; i < 16; i++) ram[i] <= rom(2'd0, 2'(i));
        end else begin
            jogar_q <= jogar;
            tem_q   <= |botoes;
            leds    <= leds_next;
            if (press) jogada <= botoes;
            if (dispara) begin
                ganhou  <= 1'b0;
                perdeu  <= 1'b0;
                timeout <= 1'b0;
                pronto  <= 1'b0;
                addr    <= '0;
                estado  <= (memoria == 2'd3 && quer_escrever) ? ESCREVE : PREPARA;
            end else begin
                case (estado)
                    ESCREVE: if (!pronto && press) begin
                        ram[addr] <= botoes;
                        addr      <= addr + 4'd1;
                        if (addr == 4'd15) pronto <= 1'b1;
                    end
                    PREPARA: begin
                        addr   <= '0;
                        fim    <= {2'b00, nivel};
                        niv    <= nivel;
                        inicio <= '0;
                        timer  <= '0;
                        estado <= MOSTRA;
                    end
                    MOSTRA: if (timer == SEC_M1) begin
                        timer <= '0;
                        if (addr == fim) estado <= ESPERA;
                        else addr <= addr + 4'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                    ESPERA: begin
                        addr   <= inicio;
                        cont   <= '0;
                        timer  <= '0;
                        estado <= JOGADA;
                    end
                    JOGADA: if (press) begin
                        estado <= COMPARA;
                    end else if (!ignora_timeout && timer >= limite_m1) begin
                        timeout <= 1'b1;
                        perdeu  <= 1'b1;
                        pronto  <= 1'b1;
                        der     <= der + 4'd1;
                        estado  <= PERDEU;
                    end else if (timer < limite_m1) begin
                        timer <= timer + 1'b1;
                    end
                    COMPARA: if (!igual) begin
                        perdeu <= 1'b1;
                        pronto <= 1'b1;
                        der    <= der + 4'd1;
                        estado <= PERDEU;
                    end else if (addr == fim) begin
                        estado <= FIM_RODADA;
                    end else begin
                        addr   <= addr + 4'd1;
                        cont   <= cont + 2'd1;
                        timer  <= '0;
                        estado <= JOGADA;
                    end
                    // The last round is truncated at entry 15.
                    FIM_RODADA: if (fim == 4'd15) begin
                        ganhou <= 1'b1;
                        pronto <= 1'b1;
                        vit    <= vit + 4'd1;
                        estado <= GANHOU;
                    end else begin
                        inicio <= fim + 4'd1;
                        fim    <= soma[4] ? 4'd15 : soma[3:0];
                        addr   <= '0;
                        timer  <= '0;
                        estado <= MOSTRA;
                    end
                    INICIAL, GANHOU, PERDEU: ;
                    default: estado <= INICIAL;
                endcase
            end
        end
    end

    assign buzzer                    = |leds;
    assign db_tem_jogada             = |botoes;
    assign db_chavesIgualMemoria     = igual;
    assign db_enderecoIgualSequencia = (estado != INICIAL) && (addr == fim);
    assign db_fimS                   = (fim == 4'd15);
    assign db_contagem               = hex7(addr);
    assign db_memoria                = hex7(mem_data);
    assign db_jogadafeita            = hex7(jogada);
    assign db_sequencia              = hex7(fim);
    assign db_estado                 = hex7(estado);
    assign db_seletor_memoria        = (memoria == 2'd3);
    assign db_pare                   = (estado == ESPERA);
    assign db_contagem_jogo          = cont;
    assign vitorias                  = hex7(vit);
    assign derrotas                  = hex7(der);
endmodule

// File: tb/tb_jogo_playseq.sv
// Randomized game-level bench for jogo_playseq: a rule-based model predicts the
// shown sequence, round ends, outcomes and tallies; one process checks every cycle.
module tb_jogo_playseq;
    localparam int CPS  = 20;
    localparam int HALF = CPS / 2;

    logic       clockFPGA = 1'b0, reset = 1'b0, jogar = 1'b0;
    logic [3:0] botoes = '0;
    logic [1:0] nivel = '0, memoria = '0, timeoutD = 2'd3;
    logic       quer_escrever = 1'b0, ignora_timeout = 1'b0;
    logic       ganhou, perdeu, timeout, pronto, buzzer, db_clock, db_tem_jogada;
    logic       db_chavesIgualMemoria, db_enderecoIgualSequencia, db_fimS;
    logic       db_seletor_memoria, db_pare;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_sequencia, db_estado;
    logic [6:0] vitorias, derrotas;
    logic [1:0] db_contagem_jogo;

    jogo_playseq #(.CYCLES_PER_SEC(CPS)) dut (
        .clockFPGA(clockFPGA), .reset(reset), .jogar(jogar), .botoes(botoes),
        .nivel(nivel), .memoria(memoria), .quer_escrever(quer_escrever),
        .timeoutD(timeoutD), .ignora_timeout(ignora_timeout),
        .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .pronto(pronto),
        .leds(leds), .buzzer(buzzer), .db_clock(db_clock), .db_tem_jogada(db_tem_jogada),
        .db_chavesIgualMemoria(db_chavesIgualMemoria),
        .db_enderecoIgualSequencia(db_enderecoIgualSequencia), .db_fimS(db_fimS),
        .db_contagem(db_contagem), .db_memoria(db_memoria), .db_jogadafeita(db_jogadafeita),
        .db_sequencia(db_sequencia), .db_estado(db_estado),
        .db_seletor_memoria(db_seletor_memoria), .db_pare(db_pare),
        .db_contagem_jogo(db_contagem_jogo), .vitorias(vitorias), .derrotas(derrotas)
    );

    always #5 clockFPGA = ~clockFPGA;

    int n_cmp = 0, n_err = 0;
    int wins = 0, losses = 0;
    logic [3:0] model_ram [16];
    logic [3:0] exp_show [$];

    function automatic logic [6:0] seg(input int v);
        case (v & 15)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
           12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] exp_mem(input int sel, input int i);
        int p;
        p = i % 4;
        case (sel)
            0: return 4'(1 << p);
            1: return 4'(8 >> p);
            2: case (p) 0: return 4'd1; 1: return 4'd4; 2: return 4'd2; default: return 4'd8; endcase
            default: return model_ram[i];
        endcase
    endfunction

    function automatic int next_end(input int e, input int niv);
        return (e + niv + 1 > 15) ? 15 : e + niv + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle checks: combinational relations, db_clock period and shown entries.
    int cycn = 0, last_tog = -1, last_pulse = -1, plen = 0;
    bit in_show = 0, gap = 1;
    logic prev_clk = 0;
    logic [3:0] prev_leds = '0;
    always @(negedge clockFPGA) begin
        cycn++;
        if (!reset) begin
            last_tog = -1; in_show = 0; gap = 1; prev_leds = '0; prev_clk = 0;
        end else begin
            check("buzzer", buzzer, |leds);
            check("tem_jogada", db_tem_jogada, |botoes);
            check("seletor", db_seletor_memoria, memoria == 2'd3);
            if (db_clock != prev_clk) begin
                if (last_tog >= 0) check("db_clock_half", cycn - last_tog, HALF);
                last_tog = cycn;
            end
            if (db_estado != seg(4)) gap = 1;
            if (in_show) begin
                if (leds != 0) plen++;
                else begin check("show_len", plen, HALF); in_show = 0; end
            end
            if (leds != 0 && prev_leds == 0 && db_estado == seg(4)) begin
                if (exp_show.size() == 0) check("show_unexpected", leds, 0);
                else check("show_val", leds, exp_show.pop_front());
                if (!gap) check("show_period", cycn - last_pulse, CPS);
                gap = 0; last_pulse = cycn; in_show = 1; plen = 1;
            end
            prev_leds = leds; prev_clk = db_clock;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clockFPGA);
        #1;
    endtask

    task automatic pulse_jogar();
        jogar = 1'b1; tick(2); jogar = 1'b0; tick(1);
    endtask

    task automatic press(input logic [3:0] v);
        botoes = v; tick($urandom_range(2, 6)); botoes = '0; tick(2);
    endtask

    task automatic wait_state(input int code, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (db_estado == seg(code)) begin ok = 1; break; end
            tick(1);
        end
        if (!ok) check($sformatf("wait_estado_%0h", code), db_estado, seg(code));
    endtask

    task automatic check_end(input bit won, input bit tmo);
        check("ganhou", ganhou, won);
        check("perdeu", perdeu, !won);
        check("timeout", timeout, tmo);
        check("pronto", pronto, 1);
        check("vitorias", vitorias, seg(wins));
        check("derrotas", derrotas, seg(losses));
    endtask

    // Plays a whole game; wrong_at is the index of the play answered wrongly (-1: none).
    task automatic play_game(input int sel, input int niv, input int wrong_at);
        int ends[$];
        int e, start, k;
        bit ok, wrong;
        logic [3:0] v;
        memoria = 2'(sel); nivel = 2'(niv); quer_escrever = 1'b0;
        e = niv;
        forever begin
            ends.push_back(e);
            if (e == 15) break;
            e = next_end(e, niv);
        end
        foreach (ends[r]) for (int i = 0; i <= ends[r]; i++) exp_show.push_back(exp_mem(sel, i));
        pulse_jogar();
        start = 0; k = 0;
        foreach (ends[r]) begin
            for (int i = start; i <= ends[r]; i++) begin
                wait_state(6, 40 * CPS, ok);
                if (!ok) begin exp_show.delete(); return; end
                check("contagem_jogo", db_contagem_jogo, i - start);
                check("sequencia", db_sequencia, seg(ends[r]));
                v = exp_mem(sel, i);
                wrong = (k == wrong_at);
                if (wrong) v = {v[2:0], v[3]};
                press(v);
                k++;
                if (wrong) begin
                    losses++;
                    check("estado_perdeu", db_estado, seg(13));
                    check_end(0, 0);
                    exp_show.delete();
                    return;
                end
            end
            start = ends[r] + 1;
        end
        tick(2);
        wins++;
        check("estado_ganhou", db_estado, seg(12));
        check("fimS", db_fimS, 1);
        check("show_left", exp_show.size(), 0);
        check_end(1, 0);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int exp_ends[6] = '{2, 5, 8, 11, 14, 15};
        int e, cnt;
        bit ok;
        logic [3:0] v;

        for (int i = 0; i < 16; i++) model_ram[i] = exp_mem(0, i);
        tick(20);
        check("rst_ganhou", ganhou, 0);
        check("rst_perdeu", perdeu, 0);
        check("rst_timeout", timeout, 0);
        check("rst_pronto", pronto, 0);
        check("rst_estado", db_estado, 7'h40);
        check("rst_leds", leds, 0);
        check("rst_vitorias", vitorias, 7'h40);
        check("rst_derrotas", derrotas, 7'h40);
        reset = 1'b1;
        tick(2);

        check("rom0_5", exp_mem(0, 5), 2);
        check("rom1_0", exp_mem(1, 0), 8);
        check("rom2_1", exp_mem(2, 1), 4);
        check("rom2_2", exp_mem(2, 2), 2);
        e = 2;
        for (int r = 0; r < 6; r++) begin
            check("round_end", e, exp_ends[r]);
            e = next_end(e, 2);
        end

        play_game(0, 2, -1);
        play_game(0, 0, 0);

        // Unanswered play must time out after exactly (timeoutD+2) seconds.
        memoria = 2'd1; nivel = 2'd1; timeoutD = 2'd2; ignora_timeout = 1'b0;
        for (int i = 0; i < 2; i++) exp_show.push_back(exp_mem(1, i));
        pulse_jogar();
        wait_state(6, 40 * CPS, ok);
        cnt = 0;
        while (db_estado == seg(6) && cnt < 10 * CPS) begin cnt++; tick(1); end
        check("timeout_cycles", cnt, 4 * CPS);
        losses++;
        check_end(0, 1);
        timeoutD = 2'd3;

        ignora_timeout = 1'b1;
        memoria = 2'd2; nivel = 2'd0;
        exp_show.push_back(exp_mem(2, 0));
        pulse_jogar();
        wait_state(6, 40 * CPS, ok);
        tick(10 * CPS);
        check("ignora_estado", db_estado, seg(6));
        check("ignora_perdeu", perdeu, 0);
        check("ignora_timeout", timeout, 0);
        ignora_timeout = 1'b0;

        reset = 1'b0;
        tick(3);
        check("midrst_estado", db_estado, seg(0));
        check("midrst_vitorias", vitorias, seg(0));
        check("midrst_derrotas", derrotas, seg(0));
        check("midrst_leds", leds, 0);
        check("midrst_pronto", pronto, 0);
        wins = 0; losses = 0;
        exp_show.delete();
        reset = 1'b1;
        tick(2);

        play_game(3, 3, -1);

        memoria = 2'd3; quer_escrever = 1'b1;
        pulse_jogar();
        check("write_estado", db_estado, seg(1));
        for (int i = 0; i < 16; i++) begin
            v = 4'(1 << $urandom_range(0, 3));
            model_ram[i] = v;
            check("write_addr", db_contagem, seg(i));
            press(v);
        end
        check("write_pronto", pronto, 1);
        check("write_done_estado", db_estado, seg(1));
        play_game(3, int'($urandom_range(0, 3)), -1);

        for (int g = 0; g < 3; g++) begin
            int wa;
            wa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : -1;
            play_game(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), wa);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
